// File: rtl/mux_rr_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module   : mux_rr_scheduler_if
// Brief    : Lane-side and output-side handshake bundle for mux_rr_scheduler.
// Revision : 1.0
// ============================================================================
interface mux_rr_scheduler_if #(
    parameter int N_LANES = 4,
    parameter int DATA_W  = 8
);
    localparam int LANE_W = $clog2(N_LANES);

    logic [N_LANES-1:0]        lane_valid;
    logic [N_LANES*DATA_W-1:0] lane_data;
    logic [N_LANES-1:0]        lane_en;
    logic [N_LANES-1:0]        lane_ready;
    logic                      out_valid;
    logic [DATA_W-1:0]         out_data;
    logic [LANE_W-1:0]         out_lane;
    logic                      out_ready;
    logic                      idle;

    modport master (
        output lane_valid, lane_data, lane_en, out_ready,
        input  lane_ready, out_valid, out_data, out_lane, idle
    );

    modport slave (
        input  lane_valid, lane_data, lane_en, out_ready,
        output lane_ready, out_valid, out_data, out_lane, idle
    );
endinterface
`default_nettype wire

// File: rtl/mux_rr_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : mux_rr_scheduler
// Brief    : Round-robin burst scheduler sharing one registered output lane.
// Revision : 1.0
// ============================================================================
module mux_rr_scheduler #(
    parameter int N_LANES   = 4,
    parameter int DATA_W    = 8,
    parameter int BURST_MAX = 4
) (
    input wire clk,
    input wire reset,
    mux_rr_scheduler_if.slave bus
);
    localparam int LANE_W = $clog2(N_LANES);
    localparam int CNT_W  = $clog2(BURST_MAX + 1);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_MAX - 1);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    state_t              state_q;
    logic [LANE_W-1:0]   rr_ptr_q;
    logic [LANE_W-1:0]   grant_q;
    logic [CNT_W-1:0]    burst_cnt_q;
    logic                out_valid_q;
    logic [DATA_W-1:0]   out_data_q;
    logic [LANE_W-1:0]   out_lane_q;

    logic [N_LANES-1:0]  w_req;
    logic [LANE_W-1:0]   w_pick_d;
    logic [LANE_W-1:0]   w_idx;
    logic                w_found;
    logic                w_sel_valid;
    logic                w_sel_en;
    logic [DATA_W-1:0]   w_sel_data;
    logic                w_can_accept;
    logic                w_xfer;
    logic                w_leave;
    logic [N_LANES-1:0]  w_lane_ready;

    assign w_req        = bus.lane_valid & bus.lane_en;
    assign w_sel_valid  = bus.lane_valid[grant_q];
    assign w_sel_en     = bus.lane_en[grant_q];
    assign w_sel_data   = bus.lane_data[int'(grant_q)*DATA_W +: DATA_W];
    assign w_can_accept = w_sel_en & (~out_valid_q | bus.out_ready);
    assign w_xfer       = (state_q == S_GRANT) & w_sel_valid & w_can_accept;
    // A stalled lane keeps its grant; only the last beat or a lost request ends it.
    assign w_leave      = (w_xfer & (burst_cnt_q == LAST_BEAT)) | ~w_sel_valid | ~w_sel_en;

    // First requesting lane at or after the round-robin pointer, wrapping.
    always_comb begin
        w_pick_d = rr_ptr_q;
        w_idx    = '0;
        w_found  = 1'b0;
        for (int k = 0; k < N_LANES; k++) begin
            w_idx = rr_ptr_q + LANE_W'(k);
            if (!w_found && w_req[w_idx]) begin
                w_pick_d = w_idx;
                w_found  = 1'b1;
            end
        end
    end

    always_comb begin
        w_lane_ready = '0;
        if (state_q == S_GRANT && w_can_accept) begin
            w_lane_ready[grant_q] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            rr_ptr_q    <= '0;
            grant_q     <= '0;
            burst_cnt_q <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_lane_q  <= '0;
        end else begin
            if (w_xfer) begin
                out_data_q  <= w_sel_data;
                out_lane_q  <= grant_q;
                out_valid_q <= 1'b1;
            end else if (bus.out_ready) begin
                out_valid_q <= 1'b0;
            end

            case (state_q)
                S_IDLE: begin
                    if (w_req != '0) begin
                        grant_q     <= w_pick_d;
                        burst_cnt_q <= '0;
                        state_q     <= S_GRANT;
                    end
                end
                S_GRANT: begin
                    if (w_xfer) begin
                        burst_cnt_q <= burst_cnt_q + 1'b1;
                    end
                    if (w_leave) begin
                        state_q  <= S_IDLE;
                        rr_ptr_q <= grant_q + 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.lane_ready = w_lane_ready;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_data   = out_data_q;
    assign bus.out_lane   = out_lane_q;
    assign bus.idle       = (state_q == S_IDLE) & ~out_valid_q;
endmodule
`default_nettype wire

// File: tb/tb_mux_rr_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_mux_rr_scheduler
// Brief    : Directed self-checking bench with a per-cycle behavioural model.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_mux_rr_scheduler;
    localparam int N  = 4;
    localparam int W  = 8;
    localparam int BM = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mux_rr_scheduler_if #(.N_LANES(N), .DATA_W(W)) bus ();

    mux_rr_scheduler #(.N_LANES(N), .DATA_W(W), .BURST_MAX(BM)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Lane sources: each lane emits {lane, running count}
    logic [5:0] src [N];

    // Model: which lane owns the output, beats used, pointer, output register
    bit         m_grant;
    int         m_owner, m_cnt, m_ptr;
    bit         m_ov;
    logic [7:0] m_od;
    int         m_ol;

    logic [N-1:0] o_ready;
    logic         o_ov, o_idle;
    logic [7:0]   o_od;
    logic [1:0]   o_ol;

    int         acc_lane [$];
    logic [7:0] acc_data [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive_data();
        for (int i = 0; i < N; i++) bus.lane_data[i*W +: W] = {2'(i), src[i]};
    endtask

    task automatic model_reset();
        m_grant = 0; m_owner = 0; m_cnt = 0; m_ptr = 0;
        m_ov = 0; m_od = '0; m_ol = 0;
    endtask

    // One clock: check outputs mid-cycle, advance model, apply edge.
    task automatic cycle();
        logic [N-1:0] exp_ready;
        bit n_grant, n_ov;
        int n_owner, n_cnt, n_ptr, n_ol, xl, l;
        logic [7:0] n_od;
        @(negedge clk);
        exp_ready = '0;
        if (m_grant && bus.lane_en[m_owner] && (!m_ov || bus.out_ready)) exp_ready[m_owner] = 1'b1;
        o_ready = bus.lane_ready; o_ov = bus.out_valid; o_od = bus.out_data;
        o_ol = bus.out_lane; o_idle = bus.idle;
        chk("lane_ready", o_ready, exp_ready);
        chk("out_valid", o_ov, m_ov);
        chk("out_data", o_od, m_od);
        chk("out_lane", o_ol, m_ol);
        chk("idle", o_idle, !m_grant && !m_ov);
        if (o_ov && bus.out_ready) begin
            acc_lane.push_back(int'(o_ol));
            acc_data.push_back(o_od);
        end

        n_grant = m_grant; n_owner = m_owner; n_cnt = m_cnt; n_ptr = m_ptr;
        n_ov = m_ov; n_od = m_od; n_ol = m_ol; xl = -1;
        if (!reset) begin
            if (m_grant && exp_ready[m_owner] && bus.lane_valid[m_owner]) xl = m_owner;
            if (xl >= 0) begin
                n_ov = 1; n_od = {2'(xl), src[xl]}; n_ol = xl;
            end else if (bus.out_ready) begin
                n_ov = 0;
            end
            if (!m_grant) begin
                for (int k = 0; k < N; k++) begin
                    l = (m_ptr + k) % N;
                    if (bus.lane_valid[l] && bus.lane_en[l]) begin
                        n_owner = l; n_grant = 1; n_cnt = 0;
                        break;
                    end
                end
            end else begin
                if (xl >= 0) n_cnt = m_cnt + 1;
                if ((xl >= 0 && n_cnt == BM) || !bus.lane_valid[m_owner] || !bus.lane_en[m_owner]) begin
                    n_grant = 0; n_ptr = (m_owner + 1) % N;
                end
            end
        end

        @(posedge clk);
        #1;
        if (reset) begin
            model_reset();
        end else begin
            m_grant = n_grant; m_owner = n_owner; m_cnt = n_cnt; m_ptr = n_ptr;
            m_ov = n_ov; m_od = n_od; m_ol = n_ol;
            if (xl >= 0) src[xl] = src[xl] + 1'b1;
        end
        drive_data();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.lane_valid = '0; bus.lane_en = '1; bus.out_ready = 1'b1;
        cycle(); cycle();
        reset = 1'b0;
        for (int i = 0; i < N; i++) src[i] = '0;
        drive_data();
        acc_lane.delete(); acc_data.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : main
        logic [12:0] ovpat;
        logic [7:0]  t1_data [5];
        t1_data = '{8'h00, 8'h40, 8'h80, 8'hC0, 8'h04};

        reset = 1'b1;
        bus.lane_valid = '0; bus.lane_en = '1; bus.out_ready = 1'b1;
        for (int i = 0; i < N; i++) src[i] = '0;
        drive_data();
        model_reset();
        repeat (2) @(posedge clk);
        #1;

        // Fair rotation, full burst length, one-cycle gap between bursts
        do_reset();
        bus.lane_valid = '1; bus.lane_en = '1; bus.out_ready = 1'b1;
        ovpat = '0;
        for (int c = 0; c < 24; c++) begin
            cycle();
            if (c < 13) ovpat[c] = o_ov;
            if (c == 0) begin
                chk("t1_reset_idle", o_idle, 1);
                chk("t1_reset_ready", o_ready, 0);
            end
        end
        chk("t1_valid_pattern", ovpat, 13'b1011110111100);
        chk("t1_word_count_ok", acc_lane.size() >= 17, 1);
        for (int i = 0; i < 17; i++) chk("t1_lane_order", acc_lane[i], (i < 16) ? i / 4 : 0);
        for (int i = 0; i < 5; i++) chk("t1_burst_head_data", acc_data[i*4], t1_data[i]);

        // Backpressure mid-burst, then drain+load in the same cycle
        do_reset();
        bus.lane_valid = '1; bus.lane_en = '1;
        for (int c = 0; c < 14; c++) begin
            bus.out_ready = !(c >= 2 && c <= 4);
            cycle();
            if (c >= 2 && c <= 4) begin
                chk("t2_stall_ready", o_ready, 0);
                chk("t2_stall_data", o_od, 8'h00);
                chk("t2_stall_valid", o_ov, 1);
            end
            if (c == 5) chk("t6_drain_load_ready", o_ready, 4'b0001);
            if (c == 6) begin
                chk("t6_no_bubble", o_ov, 1);
                chk("t6_new_word", o_od, 8'h01);
            end
        end
        for (int i = 0; i < 5; i++) chk("t2_lane_order", acc_lane[i], (i < 4) ? 0 : 1);
        chk("t2_fourth_word", acc_data[3], 8'h03);
        chk("t2_lane1_word", acc_data[4], 8'h40);

        // Disabled lane never granted; enabling grants next edge
        do_reset();
        bus.lane_valid = 4'b0100; bus.lane_en = 4'b1011; bus.out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            cycle();
            chk("t3_masked_ready", o_ready, 0);
            chk("t3_masked_idle", o_idle, 1);
        end
        bus.lane_en = 4'b1111;
        cycle(); chk("t3_arb_idle", o_idle, 1);
        cycle(); chk("t3_grant_ready", o_ready, 4'b0100);
        cycle();
        chk("t3_first_valid", o_ov, 1);
        chk("t3_first_data", o_od, 8'h80);
        chk("t3_first_lane", o_ol, 2);

        // Early drop forfeits grant; pointer moves past the dropped lane
        do_reset();
        bus.lane_en = '1; bus.out_ready = 1'b1;
        for (int c = 0; c < 11; c++) begin
            bus.lane_valid = (c == 0) ? 4'b0010 : (c < 3) ? 4'b1011 : 4'b1001;
            cycle();
            if (c == 5)  chk("t4_next_lane3", o_ready, 4'b1000);
            if (c == 10) chk("t4_then_lane0", o_ready, 4'b0001);
        end

        // Reset mid-burst drops the in-flight word
        do_reset();
        bus.lane_valid = '1; bus.lane_en = '1; bus.out_ready = 1'b1;
        cycle(); cycle(); cycle();
        chk("t5_inflight", o_ov, 1);
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        cycle();
        chk("t5_drop_valid", o_ov, 0);
        chk("t5_drop_ready", o_ready, 0);
        chk("t5_drop_idle", o_idle, 1);
        cycle();
        chk("t5_lane0_first", o_ready, 4'b0001);

        // Mixed traffic, checked against the model only
        for (int c = 0; c < 80; c++) begin
            bus.lane_valid = 4'($urandom_range(0, 15));
            bus.lane_en    = 4'($urandom_range(0, 15)) | 4'b0001;
            bus.out_ready  = ($urandom_range(0, 3) != 0);
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
`default_nettype wire
